// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - decode/fetch/PC-register signal bundle for the PC sequencer
interface pc_seq_ctrl_if;
  logic       imem_ready;
  logic       stall;
  logic       supervisor;
  logic       illop;
  logic       is_jmp;
  logic       is_br;
  logic       br_taken;
  logic       irq;
  logic [2:0] PCSEL;
  logic       pc_en;
  logic       annul;
  logic       xp_wr;
  logic       irq_ack;
  logic       fetch_fault;

  modport master (
    output imem_ready, stall, supervisor, illop, is_jmp, is_br, br_taken, irq,
    input  PCSEL, pc_en, annul, xp_wr, irq_ack, fetch_fault
  );

  modport slave (
    input  imem_ready, stall, supervisor, illop, is_jmp, is_br, br_taken, irq,
    output PCSEL, pc_en, annul, xp_wr, irq_ack, fetch_fault
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - Beta PC sequencer: PCSEL/pc_en decode, trap flush, irq sync/ack
// Optional fetch-timeout fault enabled by defining FETCH_TIMEOUT_EN.
module pc_seq_ctrl #(
  parameter int IRQ_SYNC_STAGES = 2,
  parameter int FLUSH_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic          clk,
  input  logic          RESET,
  pc_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] SEL_PC4  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_ILL  = 3'd3;
  localparam logic [2:0] SEL_IRQ  = 3'd4;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 flush_q, flush_d;
  logic [IRQ_SYNC_STAGES-1:0] irq_sync_q;
  logic                       pend_q;
  logic                       irq_pending;
  logic                       to_hit;

  logic [2:0] pcsel;
  logic       pc_en, annul, xp_wr, irq_ack, fetch_fault;

  // The last sync stage counts as pending immediately so source latency equals the sync depth.
  assign irq_pending = pend_q | irq_sync_q[IRQ_SYNC_STAGES-1];

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;

  assign to_hit = (state_q == RUN) && !bus.imem_ready &&
                  (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_d = '0;
    if (state_q == RUN && !bus.imem_ready && !to_hit)
      to_d = to_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (RESET) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= RUN;
      flush_q    <= '0;
      irq_sync_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      irq_sync_q <= {irq_sync_q[IRQ_SYNC_STAGES-2:0], bus.irq};
      pend_q     <= irq_ack ? 1'b0 : irq_pending;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    pcsel       = SEL_PC4;
    pc_en       = 1'b0;
    annul       = 1'b1;
    xp_wr       = 1'b0;
    irq_ack     = 1'b0;
    fetch_fault = 1'b0;
    if (!RESET) begin
      case (state_q)
        RUN: begin
          if (to_hit) begin
            pcsel       = SEL_ILL;
            pc_en       = 1'b1;
            xp_wr       = 1'b1;
            fetch_fault = 1'b1;
            state_d     = FLUSH;
            flush_d     = 3'(FLUSH_CYCLES);
          end else if (bus.imem_ready && !bus.stall) begin
            if (bus.illop) begin
              pcsel   = SEL_ILL;
              pc_en   = 1'b1;
              xp_wr   = 1'b1;
              state_d = FLUSH;
              flush_d = 3'(FLUSH_CYCLES);
            end else if (irq_pending && !bus.supervisor) begin
              pcsel   = SEL_IRQ;
              pc_en   = 1'b1;
              xp_wr   = 1'b1;
              irq_ack = 1'b1;
              state_d = FLUSH;
              flush_d = 3'(FLUSH_CYCLES);
            end else begin
              pc_en = 1'b1;
              annul = 1'b0;
              if (bus.is_jmp)                    pcsel = SEL_JMP;
              else if (bus.is_br && bus.br_taken) pcsel = SEL_BR;
            end
          end
        end
        FLUSH: begin
          flush_d = flush_q - 3'd1;
          if (flush_q <= 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.PCSEL       = pcsel;
  assign bus.pc_en       = pc_en;
  assign bus.annul       = annul;
  assign bus.xp_wr       = xp_wr;
  assign bus.irq_ack     = irq_ack;
  assign bus.fetch_fault = fetch_fault;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for pc_seq_ctrl with a behavioural reference model
module tb_pc_seq_ctrl;
  localparam int SYNC  = 2;
  localparam int FLUSH = 1;
  localparam int TO    = 4;

  typedef struct packed {
    logic [2:0] pcsel;
    logic       pc_en;
    logic       annul;
    logic       xp_wr;
    logic       irq_ack;
    logic       fetch_fault;
  } exp_t;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  pc_seq_ctrl_if bus();

  pc_seq_ctrl #(
    .IRQ_SYNC_STAGES(SYNC),
    .FLUSH_CYCLES(FLUSH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .bus(bus)
  );

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  bit m_flush;
  int m_left;
  int m_to;
  bit m_pend;
  bit hist[$];

  function automatic exp_t mk(int sel, bit en, bit an, bit xp, bit ack, bit ff);
    exp_t e;
    e.pcsel = 3'(sel); e.pc_en = en; e.annul = an;
    e.xp_wr = xp; e.irq_ack = ack; e.fetch_fault = ff;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, got;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = {bus.PCSEL, bus.pc_en, bus.annul, bus.xp_wr, bus.irq_ack, bus.fetch_fault};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s t=%0t got sel=%0d en=%b an=%b xp=%b ack=%b ff=%b exp sel=%0d en=%b an=%b xp=%b ack=%b ff=%b",
                 t, $time, got.pcsel, got.pc_en, got.annul, got.xp_wr, got.irq_ack, got.fetch_fault,
                 e.pcsel, e.pc_en, e.annul, e.xp_wr, e.irq_ack, e.fetch_fault);
      end
    end
  end

  task automatic cyc(input string tag, input bit rst, input bit rdy, input bit stl, input bit sup,
                     input bit ill, input bit jmp, input bit br, input bit tk, input bit irq_i);
    exp_t e;
    bit   pend, fault, trap;
    @(posedge clk); #1;
    RESET = rst;
    bus.imem_ready = rdy; bus.stall = stl; bus.supervisor = sup; bus.illop = ill;
    bus.is_jmp = jmp; bus.is_br = br; bus.br_taken = tk; bus.irq = irq_i;
    e = mk(0, 0, 1, 0, 0, 0);
    if (rst) begin
      m_flush = 0; m_left = 0; m_to = 0; m_pend = 0;
      hist = {};
      repeat (SYNC) hist.push_back(1'b0);
    end else begin
      pend  = m_pend | hist[0];
      fault = 0;
      trap  = 0;
      if (m_flush) begin
        m_left--;
        if (m_left == 0) m_flush = 0;
        m_to = 0;
      end else begin
`ifdef FETCH_TIMEOUT_EN
        if (!rdy) begin
          m_to++;
          if (m_to == TO) begin fault = 1; m_to = 0; end
        end else m_to = 0;
`endif
        if (fault) begin
          e = mk(3, 1, 1, 1, 0, 1); trap = 1;
        end else if (rdy && !stl) begin
          if (ill)               begin e = mk(3, 1, 1, 1, 0, 0); trap = 1; end
          else if (pend && !sup) begin e = mk(4, 1, 1, 1, 1, 0); trap = 1; end
          else if (jmp)          e = mk(2, 1, 0, 0, 0, 0);
          else if (br && tk)     e = mk(1, 1, 0, 0, 0, 0);
          else                   e = mk(0, 1, 0, 0, 0, 0);
        end
      end
      if (trap) begin m_flush = 1; m_left = FLUSH; end
      m_pend = e.irq_ack ? 1'b0 : pend;
      void'(hist.pop_front());
      hist.push_back(irq_i);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    int  starve;
    bit  irq_r, sup_r;
    RESET = 1'b1;
    bus.imem_ready = 0; bus.stall = 0; bus.supervisor = 0; bus.illop = 0;
    bus.is_jmp = 0; bus.is_br = 0; bus.br_taken = 0; bus.irq = 0;

    //            tag            rst rdy stl sup ill jmp br tk irq
    repeat (3) cyc("reset",       1,  1,  0,  0,  0,  0, 0, 0, 0);
    cyc("reset_release_alu",      0,  1,  0,  0,  0,  0, 0, 0, 0);
    cyc("br_taken",               0,  1,  0,  0,  0,  0, 1, 1, 0);
    cyc("jmp",                    0,  1,  0,  0,  0,  1, 0, 0, 0);
    cyc("br_not_taken",           0,  1,  0,  0,  0,  0, 1, 0, 0);

    repeat (3) cyc("irq_in_kernel", 0, 1, 0, 1, 0, 0, 0, 0, 1);
    repeat (2) cyc("irq_held",      0, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc("illop_over_irq",         0,  1,  0,  0,  1,  0, 0, 0, 0);
    cyc("illop_flush",            0,  1,  0,  1,  0,  0, 0, 0, 0);
    repeat (3) cyc("handler",     0,  1,  0,  1,  0,  0, 0, 0, 0);
    cyc("irq_after_handler",      0,  1,  0,  0,  0,  0, 0, 0, 0);
    cyc("irq_flush",              0,  1,  0,  0,  0,  0, 0, 0, 0);
    cyc("post_irq_alu",           0,  1,  0,  0,  0,  0, 0, 0, 0);

    repeat (20) cyc("sup_mask",   0,  1,  0,  1,  0,  0, 0, 0, 1);
    cyc("sup_mask_user",          0,  1,  0,  0,  0,  0, 0, 0, 0);
    repeat (4) cyc("sup_mask_after", 0, 1, 0, 1, 0,  0, 0, 0, 0);
    cyc("repend_user",            0,  1,  0,  0,  0,  0, 0, 0, 0);
    repeat (2) cyc("settle",      0,  1,  0,  0,  0,  0, 0, 0, 0);

    repeat (3) cyc("stall_irq_src", 0, 1, 0, 1, 0,  0, 0, 0, 1);
    repeat (2) cyc("stall_irq_gap", 0, 1, 0, 1, 0,  0, 0, 0, 0);
    repeat (5) cyc("stall_hold",  0,  1,  1,  0,  0,  0, 0, 0, 0);
    cyc("stall_drop",             0,  1,  0,  0,  0,  0, 0, 0, 0);
    repeat (2) cyc("settle",      0,  1,  0,  0,  0,  0, 0, 0, 0);

    repeat (4) cyc("fetch_starve", 0, 0,  0,  0,  0,  0, 0, 0, 0);
    repeat (3) cyc("starve_recover", 0, 1, 0, 0,  0,  0, 0, 0, 0);
    repeat (9) cyc("long_starve", 0,  0,  1,  0,  0,  0, 0, 0, 0);
    cyc("starve_recover",         0,  1,  0,  0,  0,  0, 0, 0, 0);

    cyc("trap_then_reset",        0,  1,  0,  0,  1,  0, 0, 0, 0);
    cyc("reset_mid_flush",        1,  1,  0,  0,  0,  0, 0, 0, 0);
    cyc("after_reset",            0,  1,  0,  0,  0,  1, 0, 0, 0);

    starve = 0; irq_r = 0; sup_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if ($urandom_range(99) < 5)  irq_r = ~irq_r;
      if ($urandom_range(99) < 10) sup_r = ~sup_r;
      if (starve == 0 && $urandom_range(99) < 3) starve = $urandom_range(6, 2);
      if (starve > 0) begin rdy = 0; starve--; end
      else rdy = ($urandom_range(99) < 85);
      cyc("random", ($urandom_range(199) == 0), rdy, ($urandom_range(99) < 15), sup_r,
          ($urandom_range(99) < 5), ($urandom_range(99) < 15), ($urandom_range(99) < 25),
          1'($urandom_range(1)), irq_r);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Per-cycle sequencer for the Beta program counter.
- Generates PCSEL (0 = PC+4, 1 = branch, 2 = JMP, 3 = illop vector 0x80000004, 4 = interrupt vector 0x80000008) and a PC write-enable.
- Handles fetch stalls, post-trap flush, and interrupt synchronisation and acknowledge.
- Sits between instruction decode, instruction memory handshake and the PC register.

Parameters:
- IRQ_SYNC_STAGES, 2, number of flops synchronising the irq input (minimum 2).
- FLUSH_CYCLES, 1, bubble cycles after any trap (range 1..7).
- TIMEOUT_CYCLES, 64, consecutive not-ready fetch cycles before a fault (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction word valid this cycle.
- stall  in  1  downstream hazard stall; hold the current instruction.
- supervisor  in  1  current PC[31]; 1 = kernel mode.
- illop  in  1  decoded illegal opcode.
- is_jmp  in  1  decoded JMP.
- is_br  in  1  decoded BEQ/BNE.
- br_taken  in  1  branch condition true.
- irq  in  1  asynchronous level interrupt request.
- PCSEL  out  3  PC source select.
- pc_en  out  1  PC register write-enable.
- annul  out  1  current instruction must not write back.
- xp_wr  out  1  write PC+4 into XP (R30) this cycle.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.
- fetch_fault  out  1  one-cycle pulse on fetch timeout (constant 0 without the optional feature).

Behaviour:
- Reset:
  - While RESET=1: PCSEL=0, pc_en=0, annul=1, xp_wr=0, irq_ack=0, fetch_fault=0.
  - irq_pending, sync flops, flush counter and timeout counter all clear; state=RUN.
  - Reset overrides every other input in the same cycle.
  - Reset mid-flush or mid-stall aborts that activity immediately.
- irq path:
  - irq passes through IRQ_SYNC_STAGES flops.
  - irq_pending sets when the synchronised irq=1.
  - irq_pending clears only in the cycle irq_ack=1; irq_ack has priority over a new set in that cycle.
  - Source latency is IRQ_SYNC_STAGES cycles from irq to irq_pending.
- States: RUN, FLUSH.
- RUN with (imem_ready=0 or stall=1) — bubble:
  - PCSEL=0, pc_en=0, annul=1, xp_wr=0.
  - Remain in RUN; irq_pending is not consumed.
- RUN with imem_ready=1 and stall=0 — strict priority, first match wins:
  1. illop=1: PCSEL=3, pc_en=1, xp_wr=1, annul=1; go to FLUSH.
  2. irq_pending=1 and supervisor=0: PCSEL=4, pc_en=1, xp_wr=1, annul=1, irq_ack=1; go to FLUSH.
  3. is_jmp=1: PCSEL=2, pc_en=1, annul=0.
  4. is_br=1 and br_taken=1: PCSEL=1, pc_en=1, annul=0.
  5. Otherwise: PCSEL=0, pc_en=1, annul=0.
- Trap and interrupt rules:
  - Interrupts are never taken while supervisor=1; irq_pending is held until the first user-mode instruction boundary.
  - illop together with irq_pending: illop is taken, irq remains pending.
  - Branch and jump have no delay slot and no flush.
- FLUSH:
  - Counter loads FLUSH_CYCLES on entry.
  - Each cycle: pc_en=0, annul=1, PCSEL=0, xp_wr=0; counter decrements.
  - Return to RUN in the cycle after the counter reaches 0.
  - Exactly FLUSH_CYCLES bubble cycles follow a trap, independent of imem_ready.
- Output timing: all outputs are registered-state decodes, combinational from state and inputs within the cycle (zero-cycle decision latency).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) counts consecutive RUN cycles with imem_ready=0 and clears whenever imem_ready=1.
  - When the counter reaches TIMEOUT_CYCLES: PCSEL=3, pc_en=1, xp_wr=1, annul=1, fetch_fault=1 for one cycle; counter clears; enter FLUSH.
  - stall=1 with imem_ready=1 does not count.
- Disabled: no counter; the controller waits indefinitely; fetch_fault tied to 0.

Test Plan:
- Reset release: hold RESET 3 cycles, then imem_ready=1 with a plain ALU op -> during reset pc_en=0, annul=1; first cycle after release PCSEL=0, pc_en=1, annul=0.
- Branch and jump: is_br=1, br_taken=1 -> PCSEL=1, pc_en=1, no flush. Next cycle is_jmp=1 -> PCSEL=2. is_br=1, br_taken=0 -> PCSEL=0.
- Illop with pending irq: illop=1 and irq_pending=1 in the same cycle, supervisor=0 -> PCSEL=3, xp_wr=1, irq_ack=0, then FLUSH_CYCLES=1 bubble. After the handler returns to supervisor=0 -> PCSEL=4, irq_ack=1.
- Supervisor masking: irq asserted while supervisor=1 for 20 cycles -> no irq_ack. First user-mode ready cycle -> PCSEL=4, irq_ack=1 pulse, annul=1.
- Stall hold: imem_ready=1, stall=1 for 5 cycles with irq_pending=1, supervisor=0 -> pc_en=0, annul=1 for all 5 cycles, no irq_ack. Stall drop -> PCSEL=4.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4: imem_ready=0 for 4 cycles -> on the 4th cycle PCSEL=3, fetch_fault=1, xp_wr=1, then one FLUSH cycle. Same stimulus without the macro -> pc_en=0 throughout and fetch_fault=0.
